// File: rtl/rv_dec_pkg.sv
// rv_dec_pkg: shared types for the RV64I decode stage.
// Opcodes, ALU control, control bundle, immediate format, FSM state.
package rv_dec_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_I    = 2'b01,
    IMM_S    = 2'b10,
    IMM_B    = 2'b11
  } imm_fmt_t;

  typedef struct packed {
    alu_ctrl_t alu_ctrl;
    logic      reg_write;
    logic      mem_write;
    logic      branch;
    logic      mem_to_reg;
    logic      alu_src;
  } ctrl_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational immediate generator.
// Sign-extends I/S/B immediates from instr[31] to XLEN bits.
module rv_imm_gen
  import rv_dec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr_i,
  input  imm_fmt_t        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  // select and sign-extend the immediate for the given format
  always_comb begin
    imm_o = '0;
    unique case (fmt_i)
      IMM_I: imm_o = {{(XLEN-12){instr_i[31]}},
                      instr_i[31:20]};
      IMM_S: imm_o = {{(XLEN-12){instr_i[31]}},
                      instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{(XLEN-13){instr_i[31]}},
                      instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8],
                      1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV64I decode with load-use bubble and trap.
// Optional macro DEC_ITYPE_EN enables addi/andi/ori decode.
module rv_decode_stage
  import rv_dec_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_alu_ctrl,
  output logic             out_reg_write,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_mem_to_reg,
  output logic             out_alu_src,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_illegal,
  output logic             trap,
  input  logic             trap_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  ctrl_t      dec_ctrl;
  imm_fmt_t   dec_fmt;
  logic       dec_legal;
  logic       uses_rs1, uses_rs2;
  logic [XLEN-1:0] dec_imm;

  // classify the incoming instruction and build its control bundle
  always_comb begin
    dec_ctrl  = CTRL_NOP;
    dec_fmt   = IMM_NONE;
    dec_legal = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    unique case (1'b1)
      (opcode == OP_LOAD): begin
        if (funct3 != 3'b111) begin
          dec_legal           = 1'b1;
          uses_rs1            = 1'b1;
          dec_ctrl.reg_write  = 1'b1;
          dec_ctrl.mem_to_reg = 1'b1;
          dec_ctrl.alu_src    = 1'b1;
          dec_fmt             = IMM_I;
        end
      end
      (opcode == OP_STORE): begin
        if (funct3 <= 3'b011) begin
          dec_legal          = 1'b1;
          uses_rs1           = 1'b1;
          uses_rs2           = 1'b1;
          dec_ctrl.mem_write = 1'b1;
          dec_ctrl.alu_src   = 1'b1;
          dec_fmt            = IMM_S;
        end
      end
      (opcode == OP_RTYPE): begin
        dec_legal = 1'b1;
        unique case ({funct7, funct3})
          10'b0000000_000: dec_ctrl.alu_ctrl = ALU_ADD;
          10'b0100000_000: dec_ctrl.alu_ctrl = ALU_SUB;
          10'b0000000_111: dec_ctrl.alu_ctrl = ALU_AND;
          10'b0000000_110: dec_ctrl.alu_ctrl = ALU_OR;
          default:         dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
          uses_rs1           = 1'b1;
          uses_rs2           = 1'b1;
          dec_ctrl.reg_write = 1'b1;
        end
      end
      (opcode == OP_BRANCH): begin
        if (funct3 == 3'b000) begin
          dec_legal         = 1'b1;
          uses_rs1          = 1'b1;
          uses_rs2          = 1'b1;
          dec_ctrl.branch   = 1'b1;
          dec_ctrl.alu_ctrl = ALU_SUB;
          dec_fmt           = IMM_B;
        end
      end
`ifdef DEC_ITYPE_EN
      (opcode == OP_ITYPE): begin
        dec_legal = 1'b1;
        unique case (funct3)
          3'b000:  dec_ctrl.alu_ctrl = ALU_ADD;
          3'b111:  dec_ctrl.alu_ctrl = ALU_AND;
          3'b110:  dec_ctrl.alu_ctrl = ALU_OR;
          default: dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
          uses_rs1           = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.alu_src   = 1'b1;
          dec_fmt            = IMM_I;
        end else begin
          dec_ctrl = CTRL_NOP;
        end
      end
`endif
      default: ;
    endcase
  end

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (in_instr),
    .fmt_i   (dec_fmt),
    .imm_o   (dec_imm)
  );

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic            illegal_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hazard, accept;

  assign hazard = valid_q && ctrl_q.mem_to_reg &&
                  (rd_q != 5'd0) && in_valid &&
                  ((uses_rs1 && (rs1 == rd_q)) ||
                   (uses_rs2 && (rs2 == rd_q)));

  assign in_ready = (state_q == RUN) &&
                    (!valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // next state: trap on accepted illegal, leave on trap_clr
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (accept && !dec_legal) state_d = TRAP;
      TRAP:    if (trap_clr) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // output valid and saturating bubble counter
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept)
      valid_d = 1'b1;
    else if (out_ready)
      valid_d = 1'b0;
    if (hazard && out_ready && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // one-entry output payload, loaded on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= CTRL_NOP;
      imm_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      ctrl_q    <= dec_ctrl;
      imm_q     <= dec_imm;
      rd_q      <= rd;
      rs1_q     <= rs1;
      rs2_q     <= rs2;
      illegal_q <= !dec_legal;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_ctrl   = ctrl_q.alu_ctrl;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_branch     = ctrl_q.branch;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_imm        = imm_q;
  assign out_rd         = rd_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_illegal    = illegal_q;
  assign trap           = (state_q == TRAP);
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed self-checking bench for rv_decode_stage.
// Uses CNT_W=2 so counter saturation is reachable.
module tb_rv_decode_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 2;

  localparam logic [31:0] I_LD   = 32'h36A33503;
  localparam logic [31:0] I_LD0  = 32'h36A33003;
  localparam logic [31:0] I_SD   = 32'h36A33523;
  localparam logic [31:0] I_SUB  = 32'h40A30533;
  localparam logic [31:0] I_BEQ  = 32'h14A30563;
  localparam logic [31:0] I_ADD  = 32'h00A30533;
  localparam logic [31:0] I_ADD0 = 32'h00030533;
  localparam logic [31:0] I_ADDI = 32'hFFF30513;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [1:0]  out_alu_ctrl;
  logic out_reg_write, out_mem_write, out_branch;
  logic out_mem_to_reg, out_alu_src, out_illegal;
  logic [XLEN-1:0] out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic trap, trap_clr;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl),
    .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write),
    .out_branch(out_branch),
    .out_mem_to_reg(out_mem_to_reg),
    .out_alu_src(out_alu_src),
    .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_illegal(out_illegal),
    .trap(trap), .trap_clr(trap_clr),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic hazard_pair();
    in_valid = 1'b1;
    in_instr = I_LD;
    step();
    chk("hz_ld_valid", out_valid, 1);
    in_instr = I_ADD;
    settle();
    chk("hz_ready_lo", in_ready, 0);
    step();
    exp_stall = (exp_stall < 3) ? exp_stall + 1 : 3;
    chk("hz_bubble", out_valid, 0);
    chk("hz_cnt", stall_cnt, exp_stall);
    chk("hz_ready_hi", in_ready, 1);
    step();
    chk("hz_add_valid", out_valid, 1);
    chk("hz_add_rs2", out_rs2, 10);
    chk("hz_add_mtr", out_mem_to_reg, 0);
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    out_ready = 1'b1;
    trap_clr = 1'b0;
    repeat (2) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_rw", out_reg_write, 0);
    rst = 1'b0;
    step();

    in_valid = 1'b1;
    in_instr = I_LD;
    settle();
    chk("ld_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("ld_valid", out_valid, 1);
    chk("ld_rw", out_reg_write, 1);
    chk("ld_mtr", out_mem_to_reg, 1);
    chk("ld_src", out_alu_src, 1);
    chk("ld_alu", out_alu_ctrl, 2'b00);
    chk("ld_imm", out_imm, 64'h36A);
    chk("ld_rd", out_rd, 10);
    chk("ld_rs1", out_rs1, 6);
    chk("ld_ill", out_illegal, 0);
    step();
    chk("drop_valid", out_valid, 0);

    in_valid = 1'b1;
    in_instr = I_SD;
    step();
    chk("sd_mw", out_mem_write, 1);
    chk("sd_rw", out_reg_write, 0);
    chk("sd_imm", out_imm, 64'h36A);
    chk("sd_rs2", out_rs2, 10);
    in_instr = I_SUB;
    step();
    chk("sub_alu", out_alu_ctrl, 2'b01);
    chk("sub_rw", out_reg_write, 1);
    chk("sub_imm", out_imm, 0);
    in_instr = I_BEQ;
    step();
    chk("beq_br", out_branch, 1);
    chk("beq_alu", out_alu_ctrl, 2'b01);
    chk("beq_imm", out_imm, 330);
    chk("beq_rw", out_reg_write, 0);
    in_valid = 1'b0;
    step();

    for (int k = 0; k < 4; k++) hazard_pair();

    in_valid = 1'b1;
    in_instr = I_LD0;
    step();
    in_instr = I_ADD0;
    settle();
    chk("x0_ready", in_ready, 1);
    step();
    chk("x0_valid", out_valid, 1);
    chk("x0_rd", out_rd, 10);
    chk("x0_cnt", stall_cnt, exp_stall);
    in_valid = 1'b0;
    step();

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = I_SUB;
    step();
    in_instr = I_BEQ;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_br", out_branch, 0);
      chk("hold_alu", out_alu_ctrl, 2'b01);
      step();
    end
    out_ready = 1'b1;
    settle();
    chk("rel_ready", in_ready, 1);
    step();
    chk("tp_beq", out_branch, 1);
    in_instr = I_SD;
    step();
    chk("tp_sd", out_mem_write, 1);
    chk("tp_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("tp_drop", out_valid, 0);

    in_valid = 1'b1;
    in_instr = 32'h0;
    step();
    chk("ill_flag", out_illegal, 1);
    chk("ill_trap", trap, 1);
    chk("ill_rw", out_reg_write, 0);
    chk("ill_mw", out_mem_write, 0);
    chk("ill_br", out_branch, 0);
    in_instr = I_SUB;
    step();
    chk("trap_ready", in_ready, 0);
    chk("trap_hold", trap, 1);
    trap_clr = 1'b1;
    settle();
    chk("clr_ready", in_ready, 0);
    step();
    trap_clr = 1'b0;
    chk("clr_trap", trap, 0);
    settle();
    chk("clr_ready2", in_ready, 1);
    step();
    chk("clr_sub", out_alu_ctrl, 2'b01);
    chk("clr_ill", out_illegal, 0);

    in_instr = 32'h0;
    step();
    chk("ill2_trap", trap, 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    trap_clr = 1'b1;
    step();
    chk("rtrap_trap", trap, 0);
    chk("rtrap_valid", out_valid, 0);
    chk("rtrap_cnt", stall_cnt, 0);
    rst = 1'b0;
    trap_clr = 1'b0;
    out_ready = 1'b1;
    step();

    in_valid = 1'b1;
    in_instr = I_ADDI;
    step();
    in_valid = 1'b0;
`ifdef DEC_ITYPE_EN
    chk("addi_ill", out_illegal, 0);
    chk("addi_imm", out_imm, {64{1'b1}});
    chk("addi_src", out_alu_src, 1);
    chk("addi_rw", out_reg_write, 1);
`else
    chk("addi_ill", out_illegal, 1);
    chk("addi_trap", trap, 1);
    chk("addi_rw", out_reg_write, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered RV64I decode stage for the RISC-V core, successor to the combinational controller. It accepts instructions over a valid/ready handshake and decodes the control bundle and an XLEN-wide sign-extended immediate. Outputs are held in a one-entry output register. The stage detects load-use hazards by inserting a bubble, and halts in a trap state on illegal encodings. It sits between fetch and register-read/execute.

Parameters:
XLEN, 64, immediate/datapath width (32 or 64)
CNT_W, 16, width of saturating stall/bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents in_instr
in_ready  out  1  stage accepts in_instr this cycle
in_instr  in  32  raw instruction
out_valid  out  1  output register holds decoded instruction
out_ready  in  1  execute consumes output this cycle
out_alu_ctrl  out  2  00 add, 01 sub, 10 and, 11 or
out_reg_write  out  1  writes rd
out_mem_write  out  1  store
out_branch  out  1  beq
out_mem_to_reg  out  1  load result to rd
out_alu_src  out  1  1 = immediate operand B
out_imm  out  XLEN  sign-extended immediate
out_rd / out_rs1 / out_rs2  out  5 each  register fields
out_illegal  out  1  decoded instruction is illegal
trap  out  1  high while in TRAP state
trap_clr  in  1  leave TRAP
stall_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset: out_valid=0, all out_* control=0, out_imm=0, fields=0, trap=0, stall_cnt=0, FSM=RUN. Reset applied mid-transfer discards the held instruction.
- Latency: one cycle from accept (in_valid&&in_ready) to out_valid.
- Handshake: in_ready = (state==RUN) && (!out_valid || out_ready) && !hazard. out_* stable while out_valid && !out_ready. When out_ready and nothing is accepted, out_valid drops to 0.
- Decode:
  - Load, opcode 0000011, funct3!=111: reg_write, mem_to_reg, alu_src, add, I-imm.
  - Store, opcode 0100011, funct3<=011: mem_write, alu_src, add, S-imm.
  - R-type, opcode 0110011: funct3/funct7 000/0000000 add, 000/0100000 sub, 111/0 and, 110/0 or; reg_write; imm=0.
  - beq, opcode 1100011, funct3=000: branch, sub, B-imm with bit0=0.
  - Anything else is illegal, including all-zero.
- Immediates: sign-extended from instr[31] to XLEN.
- Illegal instruction: it is accepted and presented with out_illegal=1 and reg_write/mem_write/branch=0. The FSM enters TRAP in the same edge, which forces in_ready=0.
- TRAP exits to RUN on the cycle trap_clr=1. trap_clr in RUN is ignored.
- Hazard: hazard = out_valid && held-is-load && out_rd!=0 && in_valid && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)).
  - uses_rs1 covers all legal types. uses_rs2 covers R-type, store, beq.
  - When hazard && out_ready, the load leaves and a bubble is inserted (out_valid=0). stall_cnt increments, saturating at all-ones.
  - The dependent instruction is accepted the next cycle.
- Simultaneous events: an illegal instruction and a hazard evaluate hazard first; no accept occurs until the hazard clears. rst dominates trap_clr.

Optional Feature:
DEC_ITYPE_EN.
- Defined: opcode 0010011 decodes funct3 000 addi, 111 andi, 110 ori with reg_write, alu_src, I-imm. Other funct3 values are illegal.
- Undefined: opcode 0010011 is illegal.

Decomposition:
Package rv_dec_pkg holds:
- opcode localparams
- alu_ctrl_t enum
- ctrl_t packed struct (the control bits)
- state_t enum {RUN, TRAP}

Sub-module rv_imm_gen is combinational: instruction in, XLEN immediate out, format select.

Test Plan:
- Send 0x36A33503 (ld x10,874(x6)): next cycle out_valid=1, reg_write=1, mem_to_reg=1, alu_src=1, alu_ctrl=00, imm=0x36A, rd=10, rs1=6.
- Send 0x36A33523 (sd), then 0x40A30533 (sub), then 0x14A30563 (beq):
  - sd: mem_write=1, imm=0x36A, rs2=10.
  - sub: alu_ctrl=01, reg_write=1.
  - beq: branch=1, alu_ctrl=01, imm=330.
- Send ld x10 then 0x00A30533 (add x10,x6,x10) with out_ready=1: exactly one bubble cycle, in_ready=0 for one cycle, stall_cnt=1. Repeat with rd=x0 and expect no bubble.
- Hold out_ready=0 for 5 cycles: out_* unchanged, in_ready=0. Release, then back-to-back throughput of one per cycle.
- Send 0x00000000: out_illegal=1, trap=1, in_ready=0 until trap_clr pulse. Assert rst during TRAP: trap=0, out_valid=0.
- With DEC_ITYPE_EN, send 0xFFF30513 (addi x10,x6,-1): imm=all-ones, alu_src=1. Without the macro, the same instruction gives out_illegal=1.
